// File: rtl/sistema_speed_miner.sv
// Micro-hash nonce search engine: one nonce per clock through a 32-round unrolled pipeline.
// Optional macro TARGET_ALL_BYTES_EN: when defined, H2 must also be below target for a hit.

package sistema_speed_miner_pkg;
  typedef struct packed {
    logic [31:0]      nonce;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [7:0]       c;
    logic [15:0][7:0] w;   // sliding message window, w[0] = word used by this round
  } stage_t;
endpackage

module sistema_speed_miner_round
  import sistema_speed_miner_pkg::*;
#(
  parameter int RND = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   vld_i,
  input  stage_t st_i,
  output logic   vld_o,
  output stage_t st_o
);
  logic [7:0] k, x, nw;
  stage_t     nxt;

  always_comb begin
    k   = (RND <= 16) ? 8'h99 : 8'ha1;
    x   = (RND <= 16) ? (st_i.a ^ st_i.b) : (st_i.a ^ st_i.b ^ st_i.c);
    // next expanded word W[i+16] = W[i+13] | (W[i+7] ^ W[i+2])
    nw  = st_i.w[13] | (st_i.w[7] ^ st_i.w[2]);
    nxt = st_i;
    nxt.a = st_i.b ^ st_i.c;
    nxt.b = {st_i.c[3:0], 4'h0};
    nxt.c = x + k + st_i.w[0];
    nxt.w = {nw, st_i.w[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      st_o  <= '0;
    end else begin
      vld_o <= vld_i && !flush;
      st_o  <= nxt;
    end
  end
endmodule

module sistema_speed_miner
  import sistema_speed_miner_pkg::*;
#(
  parameter logic [31:0] NONCE_START = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] payload,
  input  logic        active,
  input  logic [7:0]  target,
  output logic        terminado,
  output logic [31:0] nonceOut,
  output logic [23:0] hashOut
);
  localparam int ROUNDS = 32;

  logic              active_q;
  logic [95:0]       pay_l;
  logic [7:0]        tgt_l;
  logic [31:0]       cnt;
  logic              iss_vld;
  logic [31:0]       iss_nonce;
  logic              vld0;
  stage_t            st0_d, st0_q;
  logic [ROUNDS:0]   vld_pipe;
  stage_t            st [ROUNDS+1];
  logic [7:0]        h0, h1, h2;
  logic              hit, hit_now, flush, issue;

  assign hit_now = vld_pipe[ROUNDS] && hit && active && !terminado;
  assign flush   = !active || hit_now;
  assign issue   = active && !terminado && !hit_now;

  // issue slot: counter value captured here, payload/target latched on the active rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      pay_l     <= '0;
      tgt_l     <= '0;
      cnt       <= NONCE_START;
      iss_vld   <= 1'b0;
      iss_nonce <= '0;
    end else begin
      active_q <= active;
      if (active && !active_q) begin
        pay_l <= payload;
        tgt_l <= target;
      end
      if (!active)    cnt <= NONCE_START;
      else if (issue) cnt <= cnt + 32'd1;
      iss_vld <= issue;
      if (issue) iss_nonce <= cnt;
    end
  end

  always_comb begin
    st0_d       = '0;
    st0_d.nonce = iss_nonce;
    st0_d.a     = 8'h01;
    st0_d.b     = 8'h89;
    st0_d.c     = 8'hfe;
    for (int j = 0; j < 12; j++) st0_d.w[j]    = pay_l[95-8*j -: 8];
    for (int j = 0; j < 4; j++)  st0_d.w[12+j] = iss_nonce[31-8*j -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0  <= 1'b0;
      st0_q <= '0;
    end else begin
      vld0  <= iss_vld && !flush;
      st0_q <= st0_d;
    end
  end

  assign vld_pipe[0] = vld0;
  assign st[0]       = st0_q;

  for (genvar s = 1; s <= ROUNDS; s++) begin : g_rnd
    sistema_speed_miner_round #(.RND(s-1)) u_rnd (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .vld_i (vld_pipe[s-1]),
      .st_i  (st[s-1]),
      .vld_o (vld_pipe[s]),
      .st_o  (st[s])
    );
  end

  always_comb begin
    h0 = st[ROUNDS].a + 8'h01;
    h1 = st[ROUNDS].b + 8'h89;
    h2 = st[ROUNDS].c + 8'hfe;
`ifdef TARGET_ALL_BYTES_EN
    hit = (h0 < tgt_l) && (h1 < tgt_l) && (h2 < tgt_l);
`else
    hit = (h0 < tgt_l) && (h1 < tgt_l);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      terminado <= 1'b0;
      nonceOut  <= '0;
      hashOut   <= '0;
    end else if (!active) begin
      terminado <= 1'b0;
    end else if (hit_now) begin
      terminado <= 1'b1;
      nonceOut  <= st[ROUNDS].nonce;
      hashOut   <= {h0, h1, h2};
    end
  end
endmodule

// File: tb/tb_sistema_speed_miner.sv
// Self-checking bench for sistema_speed_miner against a straight-line software hash model.
module tb_sistema_speed_miner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] payload;
  logic        active;
  logic [7:0]  target;
  logic        terminado;
  logic [31:0] nonceOut;
  logic [23:0] hashOut;

  int errors = 0;
  int checks = 0;

  localparam int SEARCH_LIMIT = 40000;

  typedef struct {
    logic [95:0] p;
    logic [7:0]  t;
    logic [31:0] exp_nonce;
    logic [23:0] exp_hash;
    bit          exp_found;
  } vec_t;

  vec_t tv [8];

  always #5 clk = ~clk;

  sistema_speed_miner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .payload   (payload),
    .active    (active),
    .target    (target),
    .terminado (terminado),
    .nonceOut  (nonceOut),
    .hashOut   (hashOut)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] model_hash(input logic [95:0] p, input logic [31:0] n);
    logic [7:0] w [32];
    logic [7:0] a, b, c, x, k, na, nb;
    for (int i = 0; i < 12; i++) w[i] = p[95-8*i -: 8];
    for (int i = 0; i < 4; i++)  w[12+i] = n[31-8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01; b = 8'h89; c = 8'hfe;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin k = 8'h99; x = a ^ b; end
      else         begin k = 8'ha1; x = a ^ b ^ c; end
      na = b ^ c;
      nb = c << 4;
      c  = x + k + w[i];
      a  = na;
      b  = nb;
    end
    a = a + 8'h01; b = b + 8'h89; c = c + 8'hfe;
    return {a, b, c};
  endfunction

  function automatic bit model_hit(input logic [23:0] h, input logic [7:0] t);
`ifdef TARGET_ALL_BYTES_EN
    return (h[23:16] < t) && (h[15:8] < t) && (h[7:0] < t);
`else
    return (h[23:16] < t) && (h[15:8] < t);
`endif
  endfunction

  task automatic find_first(input logic [95:0] p, input logic [7:0] t,
                            output logic [31:0] n, output bit found);
    found = 1'b0;
    n     = '0;
    for (int i = 0; i < SEARCH_LIMIT; i++) begin
      if (model_hit(model_hash(p, 32'(i)), t)) begin
        n = 32'(i);
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // active already driven high with payload/target; the next edge is the issue edge
  task automatic wait_find(input logic [95:0] p, input logic [7:0] t, input string nm);
    logic [31:0] en;
    bit          ef;
    int          cyc, lim;
    find_first(p, t, en, ef);
    if (!ef) begin
      errors++;
      $display("FAIL %s_model: no hit within %0d nonces, required a hit", nm, SEARCH_LIMIT);
      return;
    end
    lim = 40 + int'(en);
    cyc = 0;
    while (cyc < lim) begin
      tick();
      cyc++;
      if (terminado) break;
    end
    chk({nm, "_latency"}, 96'(cyc), 96'(35 + int'(en)));
    chk({nm, "_terminado"}, 96'(terminado), 96'd1);
    chk({nm, "_nonce"}, 96'(nonceOut), 96'(en));
    chk({nm, "_hash"}, 96'(hashOut), 96'(model_hash(p, en)));
    chk({nm, "_h0_lt"}, 96'(hashOut[23:16] < t), 96'd1);
    chk({nm, "_h1_lt"}, 96'(hashOut[15:8] < t), 96'd1);
  endtask

  task automatic run_search(input logic [95:0] p, input logic [7:0] t, input string nm);
    active = 1'b0;
    tick();
    chk({nm, "_idle_terminado"}, 96'(terminado), 96'd0);
    payload = p;
    target  = t;
    active  = 1'b1;
    wait_find(p, t, nm);
  endtask

  initial begin
    logic [31:0] sv_nonce;
    logic [23:0] sv_hash;
    logic [95:0] pb;

    rst_n = 1'b0; active = 1'b0; payload = '0; target = '0;
    repeat (2) tick();
    chk("reset_terminado", 96'(terminado), 96'd0);
    chk("reset_nonce", 96'(nonceOut), 96'd0);
    chk("reset_hash", 96'(hashOut), 96'd0);
    rst_n = 1'b1;
    tick();

    // vector table: expectations from the software model
    tv[0].p = 96'h397d9f2f40ca9e6c6b1f3324; tv[0].t = 8'h0a;
    tv[1].p = {$urandom, $urandom, $urandom}; tv[1].t = 8'hff;
    for (int i = 2; i < 8; i++) begin
      tv[i].p = {$urandom, $urandom, $urandom};
      tv[i].t = 8'($urandom_range(48, 255));
    end
    for (int i = 0; i < 8; i++) begin
      find_first(tv[i].p, tv[i].t, tv[i].exp_nonce, tv[i].exp_found);
      tv[i].exp_hash = model_hash(tv[i].p, tv[i].exp_nonce);
    end
    for (int i = 0; i < 8; i++) begin
      run_search(tv[i].p, tv[i].t, $sformatf("vec%0d", i));
      if (tv[i].exp_found) chk($sformatf("vec%0d_tab_nonce", i), 96'(nonceOut), 96'(tv[i].exp_nonce));
    end

    // sticky hold while inputs wiggle
    sv_nonce = nonceOut;
    sv_hash  = hashOut;
    for (int i = 0; i < 100; i++) begin
      payload = {$urandom, $urandom, $urandom};
      target  = 8'($urandom);
      tick();
      chk("sticky", {terminado, nonceOut, hashOut}, {1'b1, sv_nonce, sv_hash});
    end

    // abort after a find: flag clears, result registers hold
    active = 1'b0;
    tick();
    chk("abort_done_terminado", 96'(terminado), 96'd0);
    chk("abort_done_nonce", 96'(nonceOut), 96'(sv_nonce));
    chk("abort_done_hash", 96'(hashOut), 96'(sv_hash));

    // target 0 can never hit
    payload = {$urandom, $urandom, $urandom};
    target  = 8'h00;
    active  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk("target0", 96'(terminado), 96'd0);
    end

    // abort mid-search, then restart with a new payload
    active = 1'b0;
    tick();
    payload = 96'h397d9f2f40ca9e6c6b1f3324;
    target  = 8'h0a;
    active  = 1'b1;
    repeat (20) tick();
    pb = {$urandom, $urandom, $urandom};
    run_search(pb, 8'hc0, "abort_restart");

    // asynchronous reset mid-search, then restart with active held high
    active = 1'b0;
    tick();
    payload = {$urandom, $urandom, $urandom};
    target  = 8'h10;
    active  = 1'b1;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_terminado", 96'(terminado), 96'd0);
    chk("async_rst_nonce", 96'(nonceOut), 96'd0);
    chk("async_rst_hash", 96'(hashOut), 96'd0);
    pb = {$urandom, $urandom, $urandom};
    payload = pb;
    target  = 8'hd0;
    tick();
    rst_n = 1'b1;
    wait_find(pb, 8'hd0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
